// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter: direction encoding and legal WIDTH range.
package counter_pkg;

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    localparam int CNT_WIDTH_MIN = 2;
    localparam int CNT_WIDTH_MAX = 32;

endpackage : counter_pkg

// File: rtl/counter_next.sv
// Combinational next-state logic for mod_updown_counter.
// `COUNTER_SAT_EN selects saturating behaviour at the boundaries instead of wrapping.
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] max_val_i,
    input  logic             up_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_d_o,
    output logic             tc_d_o
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Bound checks come before the step, so the +1/-1 never needs a carry.
    always_comb begin
        count_d_o = count_i;
        tc_d_o    = 1'b0;
        if (load_i) begin
            count_d_o = (load_val_i > max_val_i) ? max_val_i : load_val_i;
            tc_d_o    = 1'b0;
        end else if (en_i) begin
            case (up_i)
                CNT_UP: begin
                    if (count_i >= max_val_i) begin
`ifdef COUNTER_SAT_EN
                        count_d_o = max_val_i;
`else
                        count_d_o = ZERO;
`endif
                        tc_d_o    = 1'b1;
                    end else begin
                        count_d_o = count_i + ONE;
                        tc_d_o    = 1'b0;
                    end
                end
                CNT_DOWN: begin
                    if (count_i == ZERO) begin
`ifdef COUNTER_SAT_EN
                        count_d_o = ZERO;
`else
                        count_d_o = max_val_i;
`endif
                        tc_d_o    = 1'b1;
                    end else if (count_i > max_val_i) begin
                        count_d_o = max_val_i;
                        tc_d_o    = 1'b0;
                    end else begin
                        count_d_o = count_i - ONE;
                        tc_d_o    = 1'b0;
                    end
                end
                default: begin
                    count_d_o = count_i;
                    tc_d_o    = 1'b0;
                end
            endcase
        end else begin
            count_d_o = count_i;
            tc_d_o    = 1'b0;
        end
    end

endmodule : counter_next

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with programmable modulus, load and registered terminal-count pulse.
// Define COUNTER_SAT_EN for saturating instead of wrapping behaviour; ports are unchanged.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] max_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             at_max_o,
    output logic             at_min_o
);

    if (WIDTH < CNT_WIDTH_MIN || WIDTH > CNT_WIDTH_MAX) begin : g_width_check
        $error("mod_updown_counter: WIDTH out of range");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;

    counter_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .count_i    (count_q),
        .max_val_i  (max_val_i),
        .up_i       (up_i),
        .en_i       (en_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .count_d_o  (count_d),
        .tc_d_o     (tc_d)
    );

    // Count and terminal-count registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= {WIDTH{1'b0}};
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count_o  = count_q;
    assign tc_o     = tc_q;
    assign at_max_o = (count_q >= max_val_i);
    assign at_min_o = (count_q == {WIDTH{1'b0}});

endmodule : mod_updown_counter

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter (WIDTH=4, wrap build): directed vectors with
// hand-computed expected count/tc, checked by an independent monitor.
module tb_mod_updown_counter;

    localparam int W = 4;

    typedef struct {
        logic         rst;
        logic         ld;
        logic [W-1:0] lv;
        logic         en;
        logic         up;
        logic [W-1:0] mx;
        logic [W-1:0] ec;
        logic         et;
    } vec_t;

    typedef struct {
        string        tag;
        logic [W-1:0] ec;
        logic         et;
        logic         emax;
        logic         emin;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         en_i = 1'b0;
    logic         up_i = 1'b1;
    logic         load_i = 1'b0;
    logic [W-1:0] load_val_i = '0;
    logic [W-1:0] max_val_i = 4'd15;
    logic [W-1:0] count_o;
    logic         tc_o;
    logic         at_max_o;
    logic         at_min_o;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mod_updown_counter #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .en_i       (en_i),
        .up_i       (up_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .max_val_i  (max_val_i),
        .count_o    (count_o),
        .tc_o       (tc_o),
        .at_max_o   (at_max_o),
        .at_min_o   (at_min_o)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic ld, input int lv, input logic en,
                       input logic up, input int mx, input int ec, input logic et);
        vec_t v;
        v.rst = rst; v.ld = ld; v.lv = W'(lv); v.en = en;
        v.up = up; v.mx = W'(mx); v.ec = W'(ec); v.et = et;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Monitor: compare DUT outputs against the scoreboard on each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, ".count"},  int'(count_o),  int'(e.ec));
                check({e.tag, ".tc"},     int'(tc_o),     int'(e.et));
                check({e.tag, ".at_max"}, int'(at_max_o), int'(e.emax));
                check({e.tag, ".at_min"}, int'(at_min_o), int'(e.emin));
            end
        end
    end

    // Stimulus: apply each vector, push its expected post-edge response.
    initial begin
        exp_t e;
        int   n;
        // reset, then full-range wrap with max 15
        add(1, 0, 0, 0, 1, 15, 0, 0);
        for (int i = 1; i <= 15; i++) add(0, 0, 0, 1, 1, 15, i, 0);
        add(0, 0, 0, 1, 1, 15, 0, 1);
        add(0, 0, 0, 1, 1, 15, 1, 0);
        // modulus 10 up
        add(0, 1, 8, 0, 1, 9, 8, 0);
        add(0, 0, 0, 1, 1, 9, 9, 0);
        add(0, 0, 0, 1, 1, 9, 0, 1);
        // down wrap
        add(0, 0, 0, 1, 0, 9, 9, 1);
        add(0, 0, 0, 1, 0, 9, 8, 0);
        add(0, 0, 0, 1, 0, 9, 7, 0);
        // load clipping with priority over en, then lowered bound while counting down
        add(0, 1, 12, 1, 1, 9, 9, 0);
        add(0, 0, 0, 1, 0, 5, 5, 0);
        add(0, 0, 0, 1, 0, 5, 4, 0);
        // count above a lowered bound while counting up wraps
        add(0, 1, 9, 0, 1, 9, 9, 0);
        add(0, 0, 0, 1, 1, 5, 0, 1);
        // max_val 0: every enabled cycle is a boundary event
        add(0, 1, 3, 0, 1, 3, 3, 0);
        add(0, 0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 1);
        // idle holds, tc drops
        add(0, 0, 0, 0, 1, 9, 0, 0);
        // reset mid-count overrides load and en
        add(0, 1, 7, 0, 1, 9, 7, 0);
        add(1, 1, 2, 1, 1, 9, 0, 0);
        add(0, 0, 0, 1, 1, 9, 1, 0);
        add(0, 0, 0, 0, 0, 9, 1, 0);

        n = 0;
        foreach (vecs[k]) begin
            @(negedge clk);
            #1;
            reset_i    = vecs[k].rst;
            load_i     = vecs[k].ld;
            load_val_i = vecs[k].lv;
            en_i       = vecs[k].en;
            up_i       = vecs[k].up;
            max_val_i  = vecs[k].mx;
            @(posedge clk);
            e.tag  = $sformatf("v%0d", n);
            e.ec   = vecs[k].ec;
            e.et   = vecs[k].et;
            e.emax = (vecs[k].ec >= vecs[k].mx);
            e.emin = (vecs[k].ec == '0);
            sb.push_back(e);
            n++;
        end
        for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_mod_updown_counter

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised synchronous up/down counter with programmable modulus, count enable, parallel load and a registered terminal-count pulse. It generalises the fixed 4-bit free-running up counter to any width and supports down counting, an arbitrary upper bound and preset. In the irrigation controller it times valve-open intervals and sensor sampling periods, with `tc` acting as the period tick.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range is 2 to 32.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `en`  in  1: count enable; one step per cycle while high.
- `up`  in  1: direction; 1 counts up, 0 counts down. Sampled only when `en` is high.
- `load`  in  1: synchronous parallel load; has priority over `en`.
- `load_val`  in  WIDTH: preset value.
- `max_val`  in  WIDTH: inclusive upper bound. The count range is 0..`max_val`. May change at any time.
- `count`  out  WIDTH: registered counter value.
- `tc`  out  1: registered one-cycle terminal-count pulse.
- `at_max`  out  1: combinational; high when `count >= max_val`.
- `at_min`  out  1: combinational; high when `count == 0`.

## Operation
Update priority on each rising edge is `reset` > `load` > `en` > hold.

- **Reset:** `count` = 0 and `tc` = 0.
- **Load:** `count` <= min(`load_val`, `max_val`) and `tc` <= 0.
- **Up count (`en`=1, `up`=1):**
  - If `count >= max_val`, this is a boundary event: wrap to 0 and set `tc` <= 1.
  - Otherwise `count` + 1 and `tc` <= 0.
- **Down count (`en`=1, `up`=0):**
  - If `count == 0`, this is a boundary event: wrap to `max_val` and set `tc` <= 1.
  - If `count > max_val` (the bound was lowered below the count), `count` <= `max_val` and `tc` <= 0.
  - Otherwise `count` - 1 and `tc` <= 0.
- **Idle (`en`=0, `load`=0):** `count` holds and `tc` <= 0.
- **`max_val` = 0:** `count` stays 0 and every enabled cycle is a boundary event.
- **Arithmetic:** modulo 2^WIDTH internally. The +1/-1 carry out is discarded because bound checks precede the step.
- **Direction change:** takes effect on the next enabled edge; there is no pipeline state to flush.

## Timing
- Latency from `en`/`load` sampled at edge N to the new `count` is visible after edge N, i.e. one cycle.
- `tc` is asserted in the same cycle that `count` shows the post-boundary value. It lasts exactly one cycle per boundary event.
- Back-to-back boundary events, for example `max_val` = 0 with `en` held, give `tc` continuously high.
- `at_max` and `at_min` follow `count` and `max_val` combinationally with no added latency.
- Reset mid-count: `count` = 0 and `tc` = 0 after the edge regardless of `load`/`en`. The first step after reset lands on the following enabled edge.

## Configuration
- **`COUNTER_SAT_EN` defined:** saturating mode. At a boundary event `count` holds at `max_val` (counting up) or at 0 (counting down) instead of wrapping. `tc` still pulses on every enabled cycle in which the step is blocked. The rule for `count > max_val` counting up changes: `count` <= `max_val`.
- **`COUNTER_SAT_EN` not defined:** wrap behaviour as described in Operation.
- The port list is identical in both builds.

## Structure
- Shared package `counter_pkg` holds:
  - the direction constants `CNT_UP` = 1'b1 and `CNT_DOWN` = 1'b0;
  - the `WIDTH` legality bounds, `CNT_WIDTH_MIN` = 2 and `CNT_WIDTH_MAX` = 32.
- One combinational sub-module, `counter_next`, computes next count and next `tc` from `count`, `max_val`, `up`, `en` and `load`/`load_val`. The top module holds only the `count`/`tc` registers, reset and the `at_max`/`at_min` flags.

## Test plan
All scenarios use `WIDTH`=4.
- **Full-range wrap:** reset, then `max_val`=15, `up`=1, `en`=1 for 17 cycles -> `count` 0,1,…,15,0,1. `tc`=1 only in the cycle `count` returns to 0.
- **Modulus 10:** `max_val`=9, up count -> `count` 8,9,0. `tc` pulses with 0. `at_max`=1 while `count`=9.
- **Down wrap:** from `count`=0 with `max_val`=9, `up`=0 -> `count` 9,8,7. `tc` pulses with 9 only.
- **Load clipping and priority:** `load`=1 with `load_val`=12, `max_val`=9 and `en`=1 in the same cycle -> `count`=9 and `tc`=0. Lowering `max_val` to 5 while `count`=9 and counting down -> `count`=5.
- **Saturating build (`COUNTER_SAT_EN`):** `max_val`=9, up, from 8 -> `count` 9,9,9. `tc`=0,1,1.
- **Reset mid-count:** `count`=7, `en`=1, `load`=1, `reset`=1 for one cycle -> `count`=0 and `tc`=0. The next enabled up edge gives 1.
